// File: rtl/partial_sum_acc_if.sv
// partial_sum_acc_if
// Bundles the beat input, its controls and the accumulated result of
// partial_sum_acc.
//   master : drives mode, data_e, data_in, acc_len; observes data_out,
//            data_e_out, busy (producer/consumer side, e.g. a testbench)
//   slave  : the accumulator itself
//   mode       0 = reload parameters, 1 = calculate
//   data_e     input beat valid
//   data_in    raw signed macro outputs, [N_MACRO][N_CH] x IN_DW
//   acc_len    beats per output group (0 behaves as 1)
//   data_out   accumulated result per channel, N_CH x OUT_DW signed
//   data_e_out single-cycle result-valid pulse
//   busy       a group is partially accumulated
`timescale 1ns/1ps
interface partial_sum_acc_if #(
    parameter int N_MACRO = 4,
    parameter int N_CH    = 64,
    parameter int IN_DW   = 4,
    parameter int OUT_DW  = 16,
    parameter int CNT_W   = 4
);
    logic                     mode;
    logic                     data_e;
    logic signed [IN_DW-1:0]  data_in [N_MACRO][N_CH];
    logic        [CNT_W-1:0]  acc_len;
    logic signed [OUT_DW-1:0] data_out [N_CH];
    logic                     data_e_out;
    logic                     busy;

    modport master (
        output mode, data_e, data_in, acc_len,
        input  data_out, data_e_out, busy
    );

    modport slave (
        input  mode, data_e, data_in, acc_len,
        output data_out, data_e_out, busy
    );
endinterface

// File: rtl/partial_sum_acc.sv
// partial_sum_acc
// Sums N_MACRO decoded macro outputs per channel on every beat
// (mode==1 && data_e==1) and accumulates acc_len beats into one result per
// channel. The result is registered onto data_out together with a
// one-cycle data_e_out pulse, one cycle after the group's last beat.
// Ports:
//   clk   rising-edge system clock
//   rst_n asynchronous active-low reset
//   bus   partial_sum_acc_if.slave (mode, data_e, data_in, acc_len,
//         data_out, data_e_out, busy)
// Build option:
//   PARTIAL_SUM_ACC_SAT_EN  saturate the final sum to the OUT_DW range;
//                           when undefined the low OUT_DW bits are taken.
`timescale 1ns/1ps
module partial_sum_acc #(
    parameter int N_MACRO = 4,
    parameter int N_CH    = 64,
    parameter int IN_DW   = 4,
    parameter int OUT_DW  = 16,
    parameter int CNT_W   = 4
) (
    input logic              clk,
    input logic              rst_n,
    partial_sum_acc_if.slave bus
);
    // Wide enough for 2^CNT_W-1 beats of the largest beat sum.
    localparam int ACC_W = OUT_DW + CNT_W;

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                   state;
    logic        [CNT_W-1:0]  cnt_p1;
    logic        [CNT_W-1:0]  len_p1;
    logic signed [ACC_W-1:0]  acc_p1  [N_CH];
    logic signed [OUT_DW-1:0] dout_p1 [N_CH];
    logic                     vld_p1;

    logic signed [ACC_W-1:0]  beat_sum_p0 [N_CH];
    logic signed [ACC_W-1:0]  acc_next_p0 [N_CH];
    logic        [CNT_W-1:0]  len_eff_p0;
    logic        [CNT_W-1:0]  cnt_inc_p0;
    logic                     last_p0;

    // Macro outputs are sign bit + inverted magnitude bits; flipping the
    // low bits back gives the two's-complement value, then sign-extend.
    function automatic logic signed [ACC_W-1:0] decode_ext(input logic [IN_DW-1:0] raw);
        logic [IN_DW-1:0] d;
        d = {raw[IN_DW-1], ~raw[IN_DW-2:0]};
        return {{(ACC_W-IN_DW){d[IN_DW-1]}}, d};
    endfunction

    function automatic logic signed [OUT_DW-1:0] finalize(input logic signed [ACC_W-1:0] v);
`ifdef PARTIAL_SUM_ACC_SAT_EN
        // In range only when all bits above the OUT_DW sign bit match it.
        if (!v[ACC_W-1] && (|v[ACC_W-2:OUT_DW-1]))
            return {1'b0, {(OUT_DW-1){1'b1}}};
        if (v[ACC_W-1] && !(&v[ACC_W-2:OUT_DW-1]))
            return {1'b1, {(OUT_DW-1){1'b0}}};
        return v[OUT_DW-1:0];
`else
        return v[OUT_DW-1:0];
`endif
    endfunction

    // ---- p0: decode, beat sum, next accumulator, group-end detect ----
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            beat_sum_p0[c] = '0;
            for (int m = 0; m < N_MACRO; m++)
                beat_sum_p0[c] = beat_sum_p0[c] + decode_ext(bus.data_in[m][c]);
            acc_next_p0[c] = (state == ACC) ? acc_p1[c] + beat_sum_p0[c] : beat_sum_p0[c];
        end
    end

    assign len_eff_p0 = (bus.acc_len == '0) ? CNT_W'(1) : bus.acc_len;
    assign cnt_inc_p0 = cnt_p1 + 1'b1;
    // A group starting in IDLE uses the live acc_len; a running group
    // compares against the length latched at its first beat.
    assign last_p0    = (state == IDLE) ? (len_eff_p0 == CNT_W'(1)) : (cnt_inc_p0 == len_p1);

    // ---- p1: accumulator, FSM and registered result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_p1 <= '0;
            len_p1 <= '0;
            vld_p1 <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc_p1[c]  <= '0;
                dout_p1[c] <= '0;
            end
        end else begin
            vld_p1 <= 1'b0;
            if (!bus.mode) begin
                state  <= IDLE;
                cnt_p1 <= '0;
            end else if (bus.data_e) begin
                for (int c = 0; c < N_CH; c++)
                    acc_p1[c] <= acc_next_p0[c];
                if (state == IDLE)
                    len_p1 <= len_eff_p0;
                if (last_p0) begin
                    for (int c = 0; c < N_CH; c++)
                        dout_p1[c] <= finalize(acc_next_p0[c]);
                    vld_p1 <= 1'b1;
                    state  <= IDLE;
                    cnt_p1 <= '0;
                end else begin
                    state  <= ACC;
                    cnt_p1 <= (state == IDLE) ? CNT_W'(1) : cnt_inc_p0;
                end
            end
        end
    end

    assign bus.data_out   = dout_p1;
    assign bus.data_e_out = vld_p1;
    assign bus.busy       = (state == ACC);
endmodule

// File: tb/tb_partial_sum_acc.sv
`timescale 1ns/1ps
module tb_partial_sum_acc;
    localparam int N_MACRO = 4;
    localparam int N_CH    = 64;
    localparam int IN_DW   = 4;
    localparam int OUT_DW  = 16;
    localparam int CNT_W   = 4;
    localparam int N_CH2   = 4;
    localparam int OUT_DW2 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    partial_sum_acc_if #(.N_MACRO(N_MACRO), .N_CH(N_CH), .IN_DW(IN_DW),
                         .OUT_DW(OUT_DW), .CNT_W(CNT_W)) bus ();
    partial_sum_acc_if #(.N_MACRO(N_MACRO), .N_CH(N_CH2), .IN_DW(IN_DW),
                         .OUT_DW(OUT_DW2), .CNT_W(CNT_W)) bus2 ();

    partial_sum_acc #(.N_MACRO(N_MACRO), .N_CH(N_CH), .IN_DW(IN_DW),
                      .OUT_DW(OUT_DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    partial_sum_acc #(.N_MACRO(N_MACRO), .N_CH(N_CH2), .IN_DW(IN_DW),
                      .OUT_DW(OUT_DW2), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: N_CH expected channel values per completed group.
    int exp_q[$];

    // Reference model state: the group being collected.
    int grp_sum [N_CH];
    int grp_beats;
    int grp_len;
    bit in_grp   = 1'b0;
    bit grp_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Raw code r means (2^(IN_DW-1)-1) - r, read as an unsigned number.
    function automatic int dec(input int r);
        return (1 << (IN_DW-1)) - 1 - r;
    endfunction

    function automatic int fin(input int s, input int w);
        int t;
`ifdef PARTIAL_SUM_ACC_SAT_EN
        if (s > (1 << (w-1)) - 1) return (1 << (w-1)) - 1;
        if (s < -(1 << (w-1)))    return -(1 << (w-1));
        return s;
`else
        t = s & ((1 << w) - 1);
        if (t >= (1 << (w-1))) t = t - (1 << w);
        return t;
`endif
    endfunction

    task automatic fill(input int kind);
        logic [IN_DW-1:0] pat;
        for (int m = 0; m < N_MACRO; m++)
            for (int c = 0; c < N_CH; c++) begin
                case (kind)
                    0: pat = 4'b0000;
                    1: pat = 4'b1111;
                    2: pat = 4'b1000;
                    default: pat = IN_DW'($urandom_range(0, (1 << IN_DW) - 1));
                endcase
                bus.data_in[m][c] = pat;
            end
    endtask

    task automatic model_beat();
        logic [IN_DW-1:0] raw;
        grp_done = 1'b0;
        if (!in_grp) begin
            grp_len   = (bus.acc_len == 0) ? 1 : int'(bus.acc_len);
            grp_beats = 0;
            for (int c = 0; c < N_CH; c++) grp_sum[c] = 0;
            in_grp = 1'b1;
        end
        for (int c = 0; c < N_CH; c++)
            for (int m = 0; m < N_MACRO; m++) begin
                raw = bus.data_in[m][c];
                grp_sum[c] += dec(int'(raw));
            end
        grp_beats++;
        if (grp_beats == grp_len) begin
            grp_done = 1'b1;
            in_grp   = 1'b0;
        end
    endtask

    // Expectations are queued only after the committing edge, so the
    // monitor sees them exactly in the cycle the pulse must appear.
    task automatic beat(input int kind);
        fill(kind);
        bus.mode   = 1'b1;
        bus.data_e = 1'b1;
        model_beat();
        @(posedge clk); #1;
        if (grp_done)
            for (int c = 0; c < N_CH; c++) exp_q.push_back(fin(grp_sum[c], OUT_DW));
    endtask

    task automatic idle(input int n);
        bus.data_e = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic mode_drop();
        bus.mode   = 1'b0;
        bus.data_e = 1'($urandom_range(0, 1));
        in_grp     = 1'b0;
        @(posedge clk); #1;
        chk("busy_in_mode0", int'(bus.busy), 0);
        bus.mode   = 1'b1;
        bus.data_e = 1'b0;
    endtask

    // Monitor: every active cycle the pulse must match whether a result is due.
    int mon_exp [N_CH];
    int mon_bad;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pulse", int'(bus.data_e_out), (exp_q.size() >= N_CH) ? 1 : 0);
            if (exp_q.size() >= N_CH) begin
                for (int c = 0; c < N_CH; c++) mon_exp[c] = exp_q.pop_front();
                if (bus.data_e_out) begin
                    mon_bad = 0;
                    for (int c = N_CH - 1; c >= 0; c--)
                        if (int'(bus.data_out[c]) != mon_exp[c]) mon_bad = c;
                    chk($sformatf("group_result_ch%0d", mon_bad),
                        int'(bus.data_out[mon_bad]), mon_exp[mon_bad]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int nz;
    initial begin
        bus.mode = 1'b0; bus.data_e = 1'b0; bus.acc_len = 4'd1;
        fill(0);
        bus2.mode = 1'b0; bus2.data_e = 1'b0; bus2.acc_len = 4'd15;
        for (int m = 0; m < N_MACRO; m++)
            for (int c = 0; c < N_CH2; c++) bus2.data_in[m][c] = 4'b0000;

        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        nz = 0;
        for (int c = 0; c < N_CH; c++) if (bus.data_out[c] != 0) nz++;
        chk("rst_data_out_nonzero", nz, 0);
        chk("rst_data_e_out", int'(bus.data_e_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beat of +7 on four macros.
        bus.acc_len = 4'd1;
        beat(0);
        chk("single_beat_value", int'(bus.data_out[0]), 28);
        chk("single_beat_value_last", int'(bus.data_out[N_CH-1]), 28);
        idle(2);

        // Three beats of -8 with a gap after the first.
        bus.acc_len = 4'd3;
        beat(1);
        chk("busy_after_first", int'(bus.busy), 1);
        idle(2);
        chk("busy_through_gap", int'(bus.busy), 1);
        beat(1);
        beat(1);
        chk("three_beat_value", int'(bus.data_out[5]), -96);
        idle(2);

        // Partial group abandoned by mode=0, then a full group of -1.
        bus.acc_len = 4'd3;
        beat(3);
        beat(3);
        mode_drop();
        beat(2); beat(2); beat(2);
        chk("after_mode_drop_value", int'(bus.data_out[9]), -12);
        idle(2);

        // Reset in the middle of a group.
        bus.acc_len = 4'd2;
        beat(3);
        rst_n = 1'b0;
        in_grp = 1'b0;
        #1;
        nz = 0;
        for (int c = 0; c < N_CH; c++) if (bus.data_out[c] != 0) nz++;
        chk("async_rst_data_out_nonzero", nz, 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_data_e_out", int'(bus.data_e_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        beat(0); beat(0);
        chk("post_rst_value", int'(bus.data_out[3]), 56);
        idle(2);

        // acc_len=0 streaming, then a length change while a group is open.
        bus.acc_len = 4'd0;
        repeat (4) beat(3);
        bus.acc_len = 4'd2;
        beat(3);
        bus.acc_len = 4'd0;
        beat(3);
        chk("latched_len_completes", int'(bus.data_e_out), 1);
        beat(3);
        bus.acc_len = 4'd3;
        beat(3);
        bus.acc_len = 4'd1;
        beat(3);
        chk("len_change_ignored", int'(bus.data_e_out), 0);
        beat(3);
        idle(2);

        // Randomized traffic with gaps, length changes and mode drops.
        repeat (300) begin
            bus.acc_len = CNT_W'($urandom_range(0, 5));
            case ($urandom_range(0, 9))
                0, 1: idle(1);
                2:    mode_drop();
                default: beat(3);
            endcase
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Narrow-output instance: 15 beats of +28 = 420.
        bus2.mode   = 1'b1;
        bus2.data_e = 1'b1;
        repeat (14) @(posedge clk); #1;
        chk("narrow_busy", int'(bus2.busy), 1);
        chk("narrow_no_early_pulse", int'(bus2.data_e_out), 0);
        @(posedge clk); #1;
        bus2.data_e = 1'b0;
        chk("narrow_pulse", int'(bus2.data_e_out), 1);
`ifdef PARTIAL_SUM_ACC_SAT_EN
        chk("narrow_value", int'(bus2.data_out[0]), 127);
`else
        chk("narrow_value", int'(bus2.data_out[0]), -92);
`endif
        chk("narrow_value_model", int'(bus2.data_out[N_CH2-1]), fin(420, OUT_DW2));
        @(posedge clk); #1;
        chk("narrow_pulse_single", int'(bus2.data_e_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/partial_sum_acc.md
PARTIAL_SUM_ACC -- requirements
Module: partial_sum_acc

Interface
REQ-001 The block SHALL have parameter N_MACRO, default 4: number of macro groups summed per beat.
REQ-002 The block SHALL have parameter N_CH, default 64: number of output channels.
REQ-003 The block SHALL have parameter IN_DW, default 4: width of each raw macro output.
REQ-004 The block SHALL have parameter OUT_DW, default 16: width of each output channel.
REQ-005 The block SHALL have parameter CNT_W, default 4: width of the acc_len port and beat counter.
REQ-006 The block SHALL have port clk, input, 1: the single system clock (rising edge).
REQ-007 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 The block SHALL have port mode, input, 1: 0 = reload parameters, 1 = calculate.
REQ-009 The block SHALL have port data_e, input, 1: input beat valid, active high.
REQ-010 The block SHALL have port data_in, input, signed IN_DW x [N_MACRO][N_CH]: raw macro outputs.
REQ-011 The block SHALL have port acc_len, input, CNT_W: beats per output group; 0 is treated as 1.
REQ-012 The block SHALL have port data_out, output, signed OUT_DW x [N_CH]: accumulated result per channel.
REQ-013 The block SHALL have port data_e_out, output, 1: single-cycle result-valid pulse.
REQ-014 The block SHALL have port busy, output, 1: high while a group is partially accumulated.

Function
REQ-015 A beat SHALL be a cycle with mode==1 and data_e==1.
REQ-016 Decode SHALL form {in[IN_DW-1], ~in[IN_DW-2:0]} as signed IN_DW, e.g. 4'b0000->+7, 4'b1111->-8, 4'b1000->-1, 4'b0111->0.
REQ-017 Beat sum per channel SHALL be the sign-extended sum of the N_MACRO decoded values.
REQ-018 Internal accumulators SHALL be OUT_DW+CNT_W bits wide, signed, and SHALL never overflow internally.
REQ-019 The FSM SHALL have states IDLE (no partial group) and ACC (partial group held); busy==(state==ACC).
REQ-020 On a beat in IDLE, acc_len SHALL be latched (0 latched as 1), the accumulator SHALL be loaded with the beat sum, and the counter SHALL be set to 1.
REQ-021 On a beat in ACC, the beat sum SHALL be added to the accumulator and the counter SHALL be incremented.
REQ-022 acc_len changes SHALL have no effect until the next group starts.
REQ-023 On the beat at which the counter reaches the latched length, data_out SHALL take the final sum at the next edge, data_e_out SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be 1 cycle from the last beat to data_e_out; back-to-back groups SHALL be accepted with no bubble.
REQ-025 With latched length 1, every beat SHALL produce an output, matching single-beat behaviour.
REQ-026 Cycles with data_e==0 and mode==1 SHALL hold the accumulator, counter and state.
REQ-027 mode==0 SHALL discard any partial group, force IDLE, counter 0, data_e_out 0, and hold data_out.
REQ-028 data_e_out SHALL be 0 in every cycle not covered by REQ-023.

Reset
REQ-029 When rst_n is low, data_out SHALL be all zero, data_e_out 0, busy 0, the counter 0, the accumulators 0 and the state IDLE, asynchronously.
REQ-030 Reset mid-group SHALL discard the partial group, and no output pulse SHALL follow.

Configuration
REQ-031 With PARTIAL_SUM_ACC_SAT_EN defined, the final sum SHALL saturate to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1] before driving data_out.
REQ-032 Without PARTIAL_SUM_ACC_SAT_EN, data_out SHALL be the low OUT_DW bits of the final sum (two's-complement wrap).

Verification
REQ-033 Defaults, acc_len=1, all data_in=4'b0000, one beat: data_out=+28 on all 64 channels and data_e_out=1 for one cycle, one cycle after the beat.
REQ-034 acc_len=3, all data_in=4'b1111, 3 beats with a 2-cycle data_e gap after beat 1: busy=1 after beat 1; data_out=-96 and a single pulse after beat 3 only.
REQ-035 OUT_DW=8, acc_len=15, all 4'b0000, 15 beats: data_out=127 with SAT_EN and -92 without.
REQ-036 acc_len=3, 2 beats, then mode=0 for 1 cycle, then 3 beats of 4'b1000: no pulse after the mode drop; next output -12; busy=0 during mode=0.
REQ-037 acc_len=2, 1 beat, then rst_n pulsed low: all outputs 0 immediately; a following 2-beat group of 4'b0000 yields +56.
REQ-038 acc_len=0 with continuous beats: pulse every cycle; acc_len changed to 2 mid-stream takes effect only at the next group start.
